// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and FSM state types for the multimode counter
package counter_pkg;
  typedef enum logic [1:0] {WRAP, SAT, ONESHOT, RSVD} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/counter_if.sv
// counter_if: signal bundle for one multimode counter instance
interface counter_if #(parameter int WIDTH = 8) (input logic clk);
  logic rst;
  logic en;
  logic load;
  logic up;
  logic start;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] step;
  logic [1:0] mode;
  logic [WIDTH-1:0] out;
  logic tc;
  logic busy;
endinterface

// File: rtl/counter_next.sv
// counter_next: combinational next count value and bound/wrap flag
module counter_next import counter_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] i_out,
  input  logic [WIDTH-1:0] i_step,
  input  logic             i_up,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_hit
);
  localparam logic [WIDTH:0]   M   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MW  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] M1W = WIDTH'(MAX_VAL+1);
  logic [WIDTH:0] w_up;
  logic w_over, w_under, w_sat, w_reached;
  assign w_up      = {1'b0, i_out} + {1'b0, i_step};
  assign w_over    = w_up > M;
  assign w_under   = i_step > i_out;
  assign w_sat     = i_mode == SAT || i_mode == ONESHOT;
  assign w_reached = i_up ? w_up >= M : i_step >= i_out;
  // wrap results stay in WIDTH bits since the modulo correction cancels the carry
  always_comb begin
    o_next = w_sat ? (i_up ? (w_over ? MW : i_out + i_step) : (w_under ? '0 : i_out - i_step))
                   : (i_up ? i_out + i_step - (w_over ? M1W : '0) : i_out - i_step + (w_under ? M1W : '0));
    o_hit  = w_sat ? w_reached && (i_mode == ONESHOT ? |i_step : i_out != (i_up ? MW : '0))
                   : (i_up ? w_over : w_under);
  end
endmodule

// File: rtl/multimode_counter.sv
// multimode_counter: up/down counter with wrap, saturate and one-shot modes
module multimode_counter import counter_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  state_e r_state, w_state_n;
  mode_e w_mode;
  logic [WIDTH-1:0] r_out, w_next;
  logic r_tc, r_busy, w_hit, w_cnt;
  assign w_mode = mode_e'(mode);
  assign w_cnt  = en && (w_mode != ONESHOT || r_state == RUN);
  assign out    = r_out;
  assign tc     = r_tc;
  assign busy   = r_busy;
  counter_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_next (
    .i_out(r_out), .i_step(step), .i_up(up), .i_mode(w_mode), .o_next(w_next), .o_hit(w_hit)
  );
  // one-shot FSM next state; load overrides this in the register block
  always_comb
    w_state_n = w_mode != ONESHOT ? IDLE
              : r_state == RUN ? (en && w_hit ? DONE : RUN)
              : (start ? RUN : r_state);
  // count register, terminal-count pulse and FSM state with registered busy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out   <= '0;
      r_tc    <= 1'b0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_out   <= in > MAXV ? MAXV : in;
      r_tc    <= 1'b0;
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      if (w_cnt) r_out <= w_next;
      r_tc    <= w_cnt && w_hit;
      r_state <= w_state_n;
      r_busy  <= w_state_n == RUN;
    end
endmodule

// File: tb/tb_multimode_counter.sv
// tb_multimode_counter: directed and randomized checks against a behavioural model
module tb_multimode_counter;
  localparam int W = 4;
  localparam int MX = 9;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  counter_if #(.WIDTH(W)) cif (.clk(clk));
  multimode_counter #(.WIDTH(W), .MAX_VAL(MX)) dut (
    .clk(clk), .rst(cif.rst), .en(cif.en), .load(cif.load), .up(cif.up), .in(cif.in),
    .step(cif.step), .mode(cif.mode), .start(cif.start), .out(cif.out), .tc(cif.tc), .busy(cif.busy)
  );
  int errors = 0;
  int checks = 0;
  int m_out, m_tc, m_st;
  bit chk_on = 1'b0;
  task automatic check(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic mreset();
    m_out = 0; m_tc = 0; m_st = 0;
  endtask
  task automatic mstep();
    int tgt, nv, bound;
    if (cif.load) begin
      m_out = cif.in > MX ? MX : int'(cif.in); m_tc = 0; m_st = 0;
      return;
    end
    m_tc = 0;
    if (cif.mode != 2) m_st = 0;
    else if (m_st != 1 && cif.start) begin
      m_st = 1;
      return;
    end
    if (!cif.en || cif.step == 0 || (cif.mode == 2 && m_st != 1)) return;
    tgt = cif.up ? m_out + int'(cif.step) : m_out - int'(cif.step);
    bound = cif.up ? MX : 0;
    if (cif.mode == 1 || cif.mode == 2) begin
      nv = tgt > MX ? MX : (tgt < 0 ? 0 : tgt);
      if (nv == bound && (cif.mode == 2 || m_out != bound)) begin
        m_tc = 1;
        if (cif.mode == 2) m_st = 2;
      end
    end else begin
      nv = tgt > MX ? tgt - (MX + 1) : (tgt < 0 ? tgt + MX + 1 : tgt);
      m_tc = int'(nv != tgt);
    end
    m_out = nv;
  endtask
  task automatic tick();
    @(posedge clk);
    if (cif.rst) mreset(); else mstep();
    #2;
  endtask
  task automatic drive(bit ld, int v, bit e, bit u, int s, int md, bit st);
    cif.load = ld; cif.in = W'(v); cif.en = e; cif.up = u; cif.step = W'(s); cif.mode = 2'(md); cif.start = st;
  endtask
  always @(negedge clk)
    if (chk_on) begin
      check("out", int'(cif.out), m_out);
      check("tc", int'(cif.tc), m_tc);
      check("busy", int'(cif.busy), int'(m_st == 1));
    end
  initial begin
    cif.rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    #1 cif.rst = 1'b1;
    #1;
    check("reset_out", int'(cif.out), 0);
    check("reset_busy", int'(cif.busy), 0);
    mreset();
    @(posedge clk);
    #2 cif.rst = 1'b0;
    chk_on = 1'b1;
    drive(1, 8, 0, 1, 4, 0, 0); tick();
    check("load8", int'(cif.out), 8);
    drive(0, 0, 1, 1, 4, 0, 0); tick();
    check("wrap_out", int'(cif.out), 2);
    check("wrap_tc", int'(cif.tc), 1);
    tick();
    check("wrap_out2", int'(cif.out), 6);
    check("wrap_tc2", int'(cif.tc), 0);
    drive(1, 5, 0, 0, 3, 1, 0); tick();
    drive(0, 0, 1, 0, 3, 1, 0); tick();
    check("sat_out1", int'(cif.out), 2);
    tick();
    check("sat_out2", int'(cif.out), 0);
    check("sat_tc2", int'(cif.tc), 1);
    tick();
    check("sat_out3", int'(cif.out), 0);
    check("sat_tc3", int'(cif.tc), 0);
    drive(1, 0, 0, 1, 3, 2, 0); tick();
    drive(0, 0, 1, 1, 3, 2, 1); tick();
    check("os_busy", int'(cif.busy), 1);
    check("os_out0", int'(cif.out), 0);
    cif.start = 1'b0;
    tick(); check("os_out3", int'(cif.out), 3);
    tick(); check("os_out6", int'(cif.out), 6);
    tick();
    check("os_out9", int'(cif.out), 9);
    check("os_tc9", int'(cif.tc), 1);
    check("os_done", int'(cif.busy), 0);
    tick();
    check("os_hold", int'(cif.out), 9);
    check("os_tc_low", int'(cif.tc), 0);
    cif.start = 1'b1; tick();
    check("os_rerun", int'(cif.busy), 1);
    cif.start = 1'b0; tick();
    check("os_rehit_tc", int'(cif.tc), 1);
    check("os_rehit_out", int'(cif.out), 9);
    tick();
    check("os_rehit_once", int'(cif.tc), 0);
    drive(1, 15, 1, 1, 3, 2, 1); tick();
    check("load_clamp", int'(cif.out), 9);
    check("load_start", int'(cif.busy), 0);
    drive(1, 0, 0, 1, 3, 2, 0); tick();
    drive(0, 0, 1, 1, 3, 2, 1); tick();
    cif.start = 1'b0;
    tick(); tick();
    check("pre_rst_out", int'(cif.out), 6);
    cif.rst = 1'b1;
    #1;
    check("arst_out", int'(cif.out), 0);
    check("arst_busy", int'(cif.busy), 0);
    mreset();
    tick();
    cif.rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_idle", int'(cif.out), 0);
    cif.start = 1'b1; tick();
    cif.start = 1'b0; tick();
    check("post_rst_run", int'(cif.out), 3);
    drive(1, 9, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("step0_out", int'(cif.out), 9);
      check("step0_tc", int'(cif.tc), 0);
    end
    for (int i = 0; i < 2000; i++) begin
      cif.rst = ($urandom_range(99) == 0);
      drive($urandom_range(9) == 0, $urandom_range(15), $urandom_range(3) != 0, 1'($urandom),
            $urandom_range(MX), ($urandom_range(7) == 0) ? $urandom_range(3) : 2, $urandom_range(4) == 0);
      if (i % 50 < 25) cif.mode = 2'($urandom_range(3));
      if (cif.rst) begin
        #1 mreset();
      end
      tick();
    end
    cif.rst = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, load-value and step width in bits.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal count; legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; no effect on load.
REQ-006 load  input  1  synchronous load of `in` into `out`.
REQ-007 up  input  1  direction; 1 = up, 0 = down.
REQ-008 in  input  WIDTH  load value.
REQ-009 step  input  WIDTH  increment/decrement magnitude per enabled cycle.
REQ-010 mode  input  2  counting mode:
  - 0 = WRAP
  - 1 = SAT
  - 2 = ONESHOT
  - 3 = reserved; behaves as WRAP.
REQ-011 start  input  1  arms a ONESHOT run.
REQ-012 out  output  WIDTH  registered count value.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 busy  output  1  high while the ONESHOT FSM is in RUN.

Function
REQ-015 Priority per edge: rst > load > count > hold.
REQ-016 Load: out <= min(in, MAX_VAL); tc <= 0; FSM -> IDLE.
REQ-017 Counting occurs when en=1 and load=0:
  - WRAP/SAT: counts in any FSM state.
  - ONESHOT: counts only in RUN.
REQ-018 step=0: out holds and tc stays 0, even when counting.
REQ-019 Arithmetic:
  - Sums are computed at WIDTH+1 bits; no intermediate overflow is permitted.
  - Up target = out+step; down target = out-step (signed).
REQ-020 WRAP up, target > MAX_VAL: out <= target-(MAX_VAL+1); tc <= 1.
REQ-021 WRAP down, target < 0: out <= target+(MAX_VAL+1); tc <= 1.
REQ-022 SAT, target beyond bound: out <= MAX_VAL (up) or 0 (down).
  - tc <= 1 only on the edge where out first reaches the bound.
  - While pinned at the bound, tc stays 0.
REQ-023 ONESHOT:
  - Counts as SAT.
  - On reaching the bound (MAX_VAL up, 0 down): tc <= 1 and FSM RUN -> DONE.
REQ-024 ONESHOT FSM transitions:
  - IDLE -start-> RUN
  - RUN -bound reached-> DONE
  - DONE -start-> RUN
  - any state -load-> IDLE
REQ-025 start while already in RUN is ignored.
REQ-026 start and load in the same cycle: load wins; FSM -> IDLE.
REQ-027 When mode != ONESHOT, the FSM is forced to IDLE on the next edge and busy=0.
REQ-028 Mode or direction changes take effect on the next edge; out is not disturbed.
REQ-029 If en=0 in RUN, the FSM stays in RUN and out holds.
REQ-030 tc is low on every cycle not named in REQ-020..023.
REQ-031 Latency: one clock from the inputs to updated out/tc/busy.

Reset
REQ-032 Asserting rst immediately, independent of clk:
  - out = 0, tc = 0, busy = 0
  - FSM = IDLE
REQ-033 Reset asserted mid-run aborts the run; after release, start is required again.
REQ-034 First state update occurs on the first rising edge after rst deasserts.

Structure
REQ-035 Package counter_pkg holds:
  - enum mode_e {WRAP, SAT, ONESHOT, RSVD}
  - enum state_e {IDLE, RUN, DONE}
REQ-036 Sub-module counter_next, purely combinational:
  - Inputs: out, step, up, mode, MAX_VAL.
  - Outputs: next value and hit-bound flag.
  - Top level holds the registers and FSM.
REQ-037 Interface counter_if is extended with en, step, mode, start, tc and busy, parameterised by WIDTH.

Verification (WIDTH=4, MAX_VAL=9)
REQ-038 WRAP up, step=4, starting at out=8 -> next out=2 with tc=1; following cycle out=6, tc=0.
REQ-039 SAT down, step=3, starting at out=5:
  - Sequence 2 -> 0 (tc=1 on the edge reaching 0) -> 0 (tc=0).
REQ-040 ONESHOT up from 0 with step=3 and a start pulse:
  - busy=1; out 3,6,9.
  - tc=1 on the 9 edge, then busy=0 and out stays 9.
  - A new start in DONE resumes RUN and holds at 9 with tc=1 once.
REQ-041 load in=15 -> out=9; load and start in the same cycle -> FSM IDLE, busy=0.
REQ-042 rst asserted between edges mid-ONESHOT at out=6:
  - out=0 and busy=0 immediately.
  - After release, no counting until start.
REQ-043 step=0 with en=1 in WRAP at out=9 -> out stays 9 and tc stays 0 for 5 cycles.
